// File: rtl/alien_fire_scheduler.sv
// Alien return-fire scheduler: round-robin column pick, lowest free bullet slot, frame cooldown.
// Optional ALIEN_FIRE_LFSR_EN: LFSR-derived round-robin start point instead of rr_ptr.
module alien_fire_scheduler #(
  parameter int unsigned NUM_COLS  = 11,
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned COOLDOWN  = 32
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 enable,
  input  logic [NUM_COLS-1:0]  col_alive,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] fire,
  output logic [3:0]           fire_col,
  output logic                 cooldown_active
);

  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_COOLDOWN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [CW-1:0]        sel_col_q, sel_col_d;
  logic [SW-1:0]        sel_slot_q, sel_slot_d;
  logic [NUM_SLOTS-1:0] fire_q, fire_d;
  logic [3:0]           fire_col_q, fire_col_d;
  logic                 cd_active_q, cd_active_d;

  logic [CW-1:0]        start_col;
  logic [CW-1:0]        found_col;
  logic [SW-1:0]        found_slot;
  logic                 col_found;
  logic                 slot_found;
  logic [CW:0]          scan_idx;

`ifdef ALIEN_FIRE_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_comb begin
    start_col = '0;
    if (32'(lfsr_q[3:0]) < NUM_COLS) begin
      start_col = CW'(lfsr_q[3:0]);
    end
  end
`else
  assign start_col = rr_ptr_q;
`endif

  // Wrapping upward scan from start_col; first living column wins.
  always_comb begin
    found_col = '0;
    col_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_COLS; k++) begin
      scan_idx = {1'b0, start_col} + (CW+1)'(k);
      if (scan_idx >= (CW+1)'(NUM_COLS)) begin
        scan_idx = scan_idx - (CW+1)'(NUM_COLS);
      end
      if (!col_found && col_alive[scan_idx[CW-1:0]]) begin
        found_col = scan_idx[CW-1:0];
        col_found = 1'b1;
      end
    end
  end

  always_comb begin
    found_slot = '0;
    slot_found = 1'b0;
    for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
      if (!slot_found && !slot_busy[j]) begin
        found_slot = SW'(j);
        slot_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    sel_col_d  = sel_col_q;
    sel_slot_d = sel_slot_q;
    fire_d     = '0;
    fire_col_d = fire_col_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && col_found && slot_found) begin
          sel_col_d  = found_col;
          sel_slot_d = found_slot;
          state_d    = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (enable && col_alive[sel_col_q] && !slot_busy[sel_slot_q]) begin
          fire_d[sel_slot_q] = 1'b1;
          fire_col_d         = 4'(sel_col_q);
          rr_ptr_d           = (32'(sel_col_q) == NUM_COLS - 1) ? '0 : sel_col_q + 1'b1;
          cnt_d              = 8'(COOLDOWN - 1);
          state_d            = ST_COOLDOWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cd_active_d = (state_d == ST_COOLDOWN);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      sel_col_q   <= '0;
      sel_slot_q  <= '0;
      fire_q      <= '0;
      fire_col_q  <= '0;
      cd_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      sel_col_q   <= sel_col_d;
      sel_slot_q  <= sel_slot_d;
      fire_q      <= fire_d;
      fire_col_q  <= fire_col_d;
      cd_active_q <= cd_active_d;
    end
  end

  assign fire            = fire_q;
  assign fire_col        = fire_col_q;
  assign cooldown_active = cd_active_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Directed self-checking bench for alien_fire_scheduler (default parameters).
module tb_alien_fire_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic        enable    = 1'b0;
  logic [10:0] col_alive = '0;
  logic [2:0]  slot_busy = '0;
  logic [2:0]  fire;
  logic [3:0]  fire_col;
  logic        cooldown_active;

  int checks = 0;
  int errors = 0;

  alien_fire_scheduler #(
    .NUM_COLS (11),
    .NUM_SLOTS(3),
    .COOLDOWN (32)
  ) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .enable         (enable),
    .col_alive      (col_alive),
    .slot_busy      (slot_busy),
    .fire           (fire),
    .fire_col       (fire_col),
    .cooldown_active(cooldown_active)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Leaves Reset low just after an edge; the next edge is the first live one.
  task automatic apply_reset(input logic [10:0] ca, input logic [2:0] sb);
    Reset     = 1'b1;
    enable    = 1'b1;
    col_alive = ca;
    slot_busy = sb;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_fire(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (fire == 3'b000 && n < limit);
  endtask

  task automatic test_reset();
    Reset = 1'b1; enable = 1'b1; col_alive = 11'h7FF; slot_busy = 3'b000;
    repeat (3) tick();
    checks++;
    if (fire !== 3'b000) begin errors++; $display("FAIL reset_fire: got %b expected 000", fire); end
    checks++;
    if (fire_col !== 4'd0) begin errors++; $display("FAIL reset_fire_col: got %0d expected 0", fire_col); end
    checks++;
    if (cooldown_active !== 1'b0) begin errors++; $display("FAIL reset_cooldown: got %b expected 0", cooldown_active); end
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset(11'h7FF, 3'b000);
    wait_fire(60, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL rr_first_latency: got %0d expected 2", n); end
    checks++;
    if (fire !== 3'b001) begin errors++; $display("FAIL rr_first_fire: got %b expected 001", fire); end
    checks++;
    if (fire_col !== 4'd0) begin errors++; $display("FAIL rr_first_col: got %0d expected 0", fire_col); end
    checks++;
    if (cooldown_active !== 1'b1) begin errors++; $display("FAIL rr_cooldown_on: got %b expected 1", cooldown_active); end
    tick();
    checks++;
    if (fire !== 3'b000) begin errors++; $display("FAIL rr_fire_one_cycle: got %b expected 000", fire); end
    wait_fire(60, n);
    checks++;
    if (n != 33) begin errors++; $display("FAIL rr_second_spacing: got %0d expected 33", n); end
    checks++;
    if (fire_col !== 4'd1) begin errors++; $display("FAIL rr_second_col: got %0d expected 1", fire_col); end
  endtask

  task automatic test_wrap();
    int n;
    apply_reset(11'h7FF, 3'b000);
    wait_fire(60, n);
    col_alive = 11'b100_0000_0001;
    wait_fire(60, n);
    checks++;
    if (n != 34 || fire_col !== 4'd10) begin
      errors++; $display("FAIL wrap_col10: got col %0d after %0d expected col 10 after 34", fire_col, n);
    end
    wait_fire(60, n);
    checks++;
    if (n != 34 || fire_col !== 4'd0) begin
      errors++; $display("FAIL wrap_col0: got col %0d after %0d expected col 0 after 34", fire_col, n);
    end
  endtask

  task automatic test_slots();
    int n;
    int seen;
    apply_reset(11'h7FF, 3'b011);
    wait_fire(60, n);
    checks++;
    if (n != 2 || fire !== 3'b100) begin
      errors++; $display("FAIL slot_pick: got %b after %0d expected 100 after 2", fire, n);
    end
    slot_busy = 3'b111;
    repeat (40) tick();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fire != 3'b000 || cooldown_active) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL slots_all_busy: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_blocked();
    int n;
    int seen;
    apply_reset(11'h7FF, 3'b000);
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire != 3'b000 || cooldown_active) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL enable_low_blocks: got %0d active cycles expected 0", seen); end
    enable = 1'b1;
    col_alive = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire != 3'b000 || cooldown_active) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL all_dead_blocks: got %0d active cycles expected 0", seen); end
    col_alive = 11'h7FF;
    wait_fire(60, n);
    checks++;
    if (n != 2 || fire_col !== 4'd0) begin
      errors++; $display("FAIL unblock_fire: got col %0d after %0d expected col 0 after 2", fire_col, n);
    end
  endtask

  task automatic test_abort();
    int n;
    apply_reset(11'h7FF, 3'b000);
    tick();
    col_alive = 11'h7FE;
    tick();
    checks++;
    if (fire !== 3'b000 || cooldown_active !== 1'b0) begin
      errors++; $display("FAIL abort_col: got fire %b cd %b expected 000 0", fire, cooldown_active);
    end
    wait_fire(60, n);
    checks++;
    if (n != 2 || fire_col !== 4'd1 || fire !== 3'b001) begin
      errors++; $display("FAIL abort_col_retry: got col %0d fire %b after %0d expected col 1 fire 001 after 2", fire_col, fire, n);
    end
    apply_reset(11'h7FF, 3'b000);
    tick();
    slot_busy = 3'b001;
    tick();
    checks++;
    if (fire !== 3'b000 || cooldown_active !== 1'b0) begin
      errors++; $display("FAIL abort_slot: got fire %b cd %b expected 000 0", fire, cooldown_active);
    end
    wait_fire(60, n);
    checks++;
    if (n != 2 || fire !== 3'b010 || fire_col !== 4'd0) begin
      errors++; $display("FAIL abort_slot_retry: got fire %b col %0d after %0d expected 010 col 0 after 2", fire, fire_col, n);
    end
  endtask

  task automatic test_reset_mid_cooldown();
    int n;
    apply_reset(11'h7FF, 3'b000);
    wait_fire(60, n);
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (cooldown_active !== 1'b0 || fire !== 3'b000) begin
      errors++; $display("FAIL mid_cd_reset: got cd %b fire %b expected 0 000", cooldown_active, fire);
    end
    Reset = 1'b0;
    wait_fire(60, n);
    checks++;
    if (n != 2 || fire_col !== 4'd0) begin
      errors++; $display("FAIL mid_cd_refire: got col %0d after %0d expected col 0 after 2", fire_col, n);
    end
  endtask

  task automatic test_enable_in_cooldown();
    int n;
    apply_reset(11'h7FF, 3'b000);
    wait_fire(60, n);
    enable = 1'b0;
    repeat (10) tick();
    checks++;
    if (cooldown_active !== 1'b1) begin errors++; $display("FAIL cd_enable_low: got %b expected 1", cooldown_active); end
    enable = 1'b1;
    wait_fire(60, n);
    checks++;
    if (n != 24 || fire_col !== 4'd1) begin
      errors++; $display("FAIL cd_enable_refire: got col %0d after %0d expected col 1 after 24", fire_col, n);
    end
  endtask

`ifdef ALIEN_FIRE_LFSR_EN
  task automatic test_lfsr();
    int n;
    int prev;
    int nonseq;
    apply_reset(11'h7FF, 3'b000);
    prev = -1;
    nonseq = 0;
    for (int i = 0; i < 64; i++) begin
      wait_fire(60, n);
      checks++;
      if (fire == 3'b000 || fire_col >= 4'd11) begin
        errors++; $display("FAIL lfsr_shot: got fire %b col %0d expected a shot with col below 11", fire, fire_col);
      end
      if (prev >= 0 && int'(fire_col) != (prev + 1) % 11) nonseq++;
      prev = int'(fire_col);
    end
    checks++;
    if (nonseq == 0) begin errors++; $display("FAIL lfsr_order: got %0d out-of-order steps expected >0", nonseq); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ALIEN_FIRE_LFSR_EN
    test_slots();
    test_lfsr();
`else
    test_round_robin();
    test_wrap();
    test_slots();
    test_blocked();
    test_abort();
    test_reset_mid_cooldown();
    test_enable_in_cooldown();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alien_fire_scheduler.md
# alien_fire_scheduler

Schedules alien return fire for the invaders playfield. Each frame it picks which alien column shoots next (round-robin over living columns) and which free alien-bullet slot carries the shot. It then issues a one-frame launch pulse to that slot's bullet instance and enforces a frame cooldown between shots. It sits between the alien-grid state (column occupancy) and the pool of alien bullet datapaths (slot busy flags).

## Interface
- NUM_COLS, 11, alien columns; legal range 2..16
- NUM_SLOTS, 3, alien bullet slots; legal range 1..8
- COOLDOWN, 32, frames from launch until the next selection may start; legal range 1..255
- frame_clk  in  1  frame clock; all logic on its rising edge
- Reset  in  1  synchronous, active-high; wins over every other input
- enable  in  1  game running; low blocks firing and aborts a pending selection
- col_alive  in  NUM_COLS  bit i set = column i has at least one alien
- slot_busy  in  NUM_SLOTS  bit j set = bullet slot j is on screen
- fire  out  NUM_SLOTS  one-hot launch pulse, registered
- fire_col  out  4  column index for the launched shot; valid while fire != 0
- cooldown_active  out  1  high while in COOLDOWN

## Operation
- States: IDLE, SELECT, COOLDOWN. Reset: state IDLE, rr_ptr=0, cnt=0, sel_col=0, sel_slot=0, fire=0, fire_col=0, cooldown_active=0.
- IDLE:
  - Selection condition: enable=1, at least one col_alive bit set, and at least one slot_busy bit clear.
  - If the condition holds, register sel_col and sel_slot, then go to SELECT. Otherwise stay in IDLE.
  - sel_col is the first set col_alive bit searching upward from the start point, wrapping at NUM_COLS-1 back to 0.
  - sel_slot is the lowest-index clear slot_busy bit.
- SELECT (exactly one cycle), re-check at the exit edge:
  - Launch when enable=1, col_alive[sel_col]=1 and slot_busy[sel_slot]=0.
  - On launch: fire <= one-hot(sel_slot), fire_col <= sel_col, rr_ptr <= sel_col+1 (NUM_COLS-1 wraps to 0), cnt <= COOLDOWN-1, state <= COOLDOWN.
  - Otherwise abort to IDLE with no fire and no cooldown.
- COOLDOWN:
  - fire is cleared after its first cycle.
  - At each edge, if cnt=0 go to IDLE, else cnt <= cnt-1.
  - enable=0 in COOLDOWN does not shorten the cooldown.
- Round-robin start point is rr_ptr.
- cnt is 8 bits. fire_col is zero-extended to 4 bits.
- col_alive may change at any time; only the sampled values at the IDLE and SELECT edges matter.

## Timing
- Selection condition true at edge N in IDLE → SELECT during cycle N..N+1 → fire high for exactly the one cycle after edge N+1.
- COOLDOWN lasts exactly COOLDOWN cycles. IDLE is re-entered at edge N+1+COOLDOWN, so the earliest next fire is at edge N+3+COOLDOWN.
- At most one fire bit is ever set; fire is never high outside the first COOLDOWN cycle.
- cooldown_active is registered and equals (state==COOLDOWN).
- Reset mid-COOLDOWN or in SELECT: all registers return to reset values at that edge; a pending fire is dropped.
- All columns dead, or all slots busy: remain in IDLE indefinitely with no output activity.

## Configuration
- ALIEN_FIRE_LFSR_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset 8'hA5) advances every cycle except during Reset.
  - The round-robin start point is lfsr[3:0] when that value is < NUM_COLS, else 0. rr_ptr is ignored for the start point.
- Not defined: no LFSR exists, and the start point is rr_ptr as described above.

## Test plan
- Reset, enable=1, col_alive=11'h7FF, slot_busy=0 → fire=3'b001 with fire_col=0 one cycle after SELECT. The next launch arrives 34 cycles after the first, with fire_col=1 (COOLDOWN=32).
- col_alive=11'b100_0000_0001, rr_ptr at 1 → fire_col=10. The following shot gives fire_col=0 (wrap-around).
- slot_busy=3'b011 → fire=3'b100. slot_busy=3'b111 → no fire and state stays IDLE for 100 cycles.
- Drop col_alive[sel_col] or set slot_busy[sel_slot] during SELECT → no fire, return to IDLE, cooldown_active stays 0. The next selection starts the following cycle.
- Assert Reset in the 5th COOLDOWN cycle → cooldown_active=0 and fire=0 after that edge. The first fire after Reset deasserts has fire_col=0.
- With ALIEN_FIRE_LFSR_EN and all columns alive → over 64 shots, fire_col does not follow strict +1 order, and every value is < 11.
